// File: rtl/aes_pkg.sv
// Shared definitions for the shared S-box controller: FSM encoding, lane geometry
// and the AES forward S-box table.
package aes_pkg;

    localparam int unsigned SBOX_LANES = 4;
    localparam int unsigned DAT_WORDS  = 4;
    localparam int unsigned WORD_W     = 8 * SBOX_LANES;
    localparam int unsigned BLK_W      = WORD_W * DAT_WORDS;
    localparam int unsigned CNT_W      = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_KEY  = 2'd1,
        ST_DAT  = 2'd2,
        ST_ACK  = 2'd3
    } state_e;

    // Block viewed as words; packed index 3 is bits [127:96] (data word 0).
    typedef logic [DAT_WORDS-1:0][WORD_W-1:0] blk_t;

    // Entry for input byte x lives at index ~x, so the table reads in natural order.
    localparam logic [255:0][7:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

endpackage

// File: rtl/sbox_share_ctrl_if.sv
// Request/acknowledge bundle between the key/data requesters and the shared S-box controller.
interface sbox_share_ctrl_if;
    import aes_pkg::*;

    logic                iKeyReq;
    logic [WORD_W-1:0]   iKeyWord;
    logic                oKeyAck;
    logic [WORD_W-1:0]   oKeyWord;
    logic                iDatReq;
    logic [BLK_W-1:0]    iDatBlock;
    logic                oDatAck;
    logic [BLK_W-1:0]    oDatBlock;
    logic                oBusy;

    modport master (
        output iKeyReq, iKeyWord, iDatReq, iDatBlock,
        input  oKeyAck, oKeyWord, oDatAck, oDatBlock, oBusy
    );

    modport slave (
        input  iKeyReq, iKeyWord, iDatReq, iDatBlock,
        output oKeyAck, oKeyWord, oDatAck, oDatBlock, oBusy
    );

endinterface

// File: rtl/sbox.sv
// Single-byte AES forward S-box lookup (combinational).
module sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte_c
);

    assign o_byte_c = SBOX_TBL[~i_byte];

endmodule

// File: rtl/sbox_word.sv
// Combinational 32-bit substitution: one S-box per byte lane.
module sbox_word
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] i_word,
    output logic [WORD_W-1:0] o_word_c
);

    for (genvar g = 0; g < int'(SBOX_LANES); g++) begin : g_lane
        sbox u_sbox (
            .i_byte   (i_word[8*g +: 8]),
            .o_byte_c (o_word_c[8*g +: 8])
        );
    end

endmodule

// File: rtl/sbox_share_ctrl.sv
// Arbitrates one 4-lane S-box datapath between a key-expansion SubWord requester
// (one cycle) and a SubBytes requester (four cycles, one word per cycle).
module sbox_share_ctrl
    import aes_pkg::*;
(
    input  logic                 iClk,
    input  logic                 iRst_n,
    sbox_share_ctrl_if.slave     bus
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               prefer_key_q, prefer_key_d;
    logic [WORD_W-1:0]  key_in_q, key_in_d;
    blk_t               dat_in_q, dat_in_d;
    logic               key_ack_q, key_ack_d;
    logic               dat_ack_q, dat_ack_d;
    logic               busy_q, busy_d;
    logic [WORD_W-1:0]  key_out_q, key_out_d;
    blk_t               dat_out_q, dat_out_d;

    logic [WORD_W-1:0]  lane_in_c;
    logic [WORD_W-1:0]  lane_out_c;
    logic               grant_key_c;

    // Data word n sits at packed index ~n, so word 0 is the top of the block.
    always_comb begin
        lane_in_c = (state_q == ST_KEY) ? key_in_q : dat_in_q[~cnt_q];
    end

    sbox_word u_sbox_word (
        .i_word   (lane_in_c),
        .o_word_c (lane_out_c)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        prefer_key_d = prefer_key_q;
        key_in_d     = key_in_q;
        dat_in_d     = dat_in_q;
        key_ack_d    = 1'b0;
        dat_ack_d    = 1'b0;
        key_out_d    = key_out_q;
        dat_out_d    = dat_out_q;
        grant_key_c  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Round-robin only matters when both ask in the same cycle.
                grant_key_c = bus.iKeyReq && (!bus.iDatReq || prefer_key_q);
                if (grant_key_c) begin
                    key_in_d     = bus.iKeyWord;
                    prefer_key_d = 1'b0;
                    state_d      = ST_KEY;
                end else if (bus.iDatReq) begin
                    dat_in_d     = blk_t'(bus.iDatBlock);
                    prefer_key_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = ST_DAT;
                end
            end
            ST_KEY: begin
                key_out_d = lane_out_c;
                key_ack_d = 1'b1;
                state_d   = ST_ACK;
            end
            ST_DAT: begin
                dat_out_d[~cnt_q] = lane_out_c;
                cnt_d             = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DAT_WORDS - 1)) begin
                    dat_ack_d = 1'b1;
                    state_d   = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            prefer_key_q <= 1'b1;
            key_in_q     <= '0;
            dat_in_q     <= '0;
            key_ack_q    <= 1'b0;
            dat_ack_q    <= 1'b0;
            busy_q       <= 1'b0;
            key_out_q    <= '0;
            dat_out_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prefer_key_q <= prefer_key_d;
            key_in_q     <= key_in_d;
            dat_in_q     <= dat_in_d;
            key_ack_q    <= key_ack_d;
            dat_ack_q    <= dat_ack_d;
            busy_q       <= busy_d;
            key_out_q    <= key_out_d;
            dat_out_q    <= dat_out_d;
        end
    end

    assign bus.oKeyAck   = key_ack_q;
    assign bus.oKeyWord  = key_out_q;
    assign bus.oDatAck   = dat_ack_q;
    assign bus.oDatBlock = BLK_W'(dat_out_q);
    assign bus.oBusy     = busy_q;

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Scoreboard bench for sbox_share_ctrl: directed requests push expected acks
// (kind, value, cycle); a negedge monitor pops and compares each ack.
module tb_sbox_share_ctrl;

    typedef struct {
        bit           is_key;
        logic [127:0] val;
        int           cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    sbox_share_ctrl_if bus ();

    sbox_share_ctrl u_dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input bit k, input logic [127:0] v, input int c);
        exp_t e;
        e.is_key = k;
        e.val    = v;
        e.cyc    = c;
        sb_q.push_back(e);
    endtask

    // Wait (bounded) for the requester's ack, then drop its request the cycle after.
    task automatic wait_ack(input bit k);
        bit got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (k ? bus.oKeyAck : bus.oDatAck) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_ack_timeout act=none exp=ack (cyc %0d)", k ? "key" : "dat", cyc);
        end
        @(posedge clk);
        #1;
        if (k) bus.iKeyReq = 1'b0;
        else   bus.iDatReq = 1'b0;
    endtask

    always @(negedge clk) begin
        if (bus.oKeyAck || bus.oDatAck) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack act=key%0b/dat%0b exp=none (cyc %0d)",
                         bus.oKeyAck, bus.oDatAck, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("ack_exclusive", 128'(bus.oKeyAck & bus.oDatAck), 128'(0));
                chk("ack_kind", 128'(bus.oKeyAck), 128'(mon_e.is_key));
                chk(mon_e.is_key ? "key_word" : "dat_block",
                    mon_e.is_key ? 128'(bus.oKeyWord) : bus.oDatBlock, mon_e.val);
                chk("ack_cycle", 128'(cyc), 128'(mon_e.cyc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        logic [31:0]  kw [2];
        logic [127:0] dw [2];
        bus.iKeyReq   = 1'b0;
        bus.iKeyWord  = '0;
        bus.iDatReq   = 1'b0;
        bus.iDatBlock = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_key_ack", 128'(bus.oKeyAck), 128'(0));
        chk("rst_dat_ack", 128'(bus.oDatAck), 128'(0));
        chk("rst_busy", 128'(bus.oBusy), 128'(0));
        chk("rst_key_word", 128'(bus.oKeyWord), 128'(0));
        chk("rst_dat_block", bus.oDatBlock, 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Data only
        @(posedge clk); #1;
        n = cyc;
        bus.iDatReq = 1'b1;
        bus.iDatBlock = 128'h000102030405060708090A0B0C0D0E0F;
        push_exp(1'b0, 128'h637C777BF26B6FC53001672BFED7AB76, n + 5);
        @(posedge clk); @(negedge clk);
        chk("busy_dat", 128'(bus.oBusy), 128'(1));
        wait_ack(1'b0);

        // Key only
        @(posedge clk); #1;
        n = cyc;
        bus.iKeyReq = 1'b1;
        bus.iKeyWord = 32'h00010253;
        push_exp(1'b1, 128'h637C77ED, n + 2);
        @(posedge clk); @(negedge clk);
        chk("busy_key", 128'(bus.oBusy), 128'(1));
        wait_ack(1'b1);

        // Both together after a key grant: data wins
        @(posedge clk); #1;
        n = cyc;
        bus.iKeyReq = 1'b1;
        bus.iKeyWord = 32'h53000000;
        bus.iDatReq = 1'b1;
        bus.iDatBlock = 128'h0F0E0D0C0B0A09080706050403020100;
        push_exp(1'b0, 128'h76ABD7FE2B670130C56F6BF27B777C63, n + 5);
        push_exp(1'b1, 128'hED636363, n + 8);
        fork
            wait_ack(1'b1);
            wait_ack(1'b0);
        join

        // Both right after reset: key wins despite last grant being key
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n = cyc;
        bus.iKeyReq = 1'b1;
        bus.iKeyWord = 32'h00112233;
        bus.iDatReq = 1'b1;
        bus.iDatBlock = 128'h5353535300000000FFFFFFFF0F0F0F0F;
        push_exp(1'b1, 128'h638293C3, n + 2);
        push_exp(1'b0, 128'hEDEDEDED636363631616161676767676, n + 8);
        fork
            wait_ack(1'b1);
            wait_ack(1'b0);
        join

        // Continuous re-assertion: key, data, key, data
        kw[0] = 32'h01020304;
        kw[1] = 32'h10203040;
        dw[0] = 128'h0;
        dw[1] = 128'h01010101020202020303030304040404;
        @(posedge clk); #1;
        n = cyc;
        push_exp(1'b1, 128'h7C777BF2, n + 2);
        push_exp(1'b0, 128'h63636363636363636363636363636363, n + 8);
        push_exp(1'b1, 128'hCAB70409, n + 11);
        push_exp(1'b0, 128'h7C7C7C7C777777777B7B7B7BF2F2F2F2, n + 17);
        fork
            begin
                for (int i = 0; i < 2; i++) begin
                    bus.iKeyReq = 1'b1;
                    bus.iKeyWord = kw[i];
                    wait_ack(1'b1);
                    if (i == 0) begin @(posedge clk); #1; end
                end
            end
            begin
                for (int j = 0; j < 2; j++) begin
                    bus.iDatReq = 1'b1;
                    bus.iDatBlock = dw[j];
                    wait_ack(1'b0);
                    if (j == 0) begin @(posedge clk); #1; end
                end
            end
        join

        // Reset in the 2nd DAT cycle aborts; held request is re-accepted
        @(posedge clk); #1;
        n = cyc;
        bus.iDatReq = 1'b1;
        bus.iDatBlock = 128'h000102030405060708090A0B0C0D0E0F;
        push_exp(1'b0, 128'h637C777BF26B6FC53001672BFED7AB76, n + 8);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_dat_ack", 128'(bus.oDatAck), 128'(0));
        chk("abort_busy", 128'(bus.oBusy), 128'(0));
        chk("abort_key_word", 128'(bus.oKeyWord), 128'(0));
        chk("abort_dat_block", bus.oDatBlock, 128'(0));
        wait_ack(1'b0);

        // Key request dropped during KEY: ack once, no re-accept
        @(posedge clk); #1;
        n = cyc;
        bus.iKeyReq = 1'b1;
        bus.iKeyWord = 32'hFFFFFFFF;
        push_exp(1'b1, 128'h16161616, n + 2);
        @(posedge clk); #1;
        bus.iKeyReq = 1'b0;
        wait_ack(1'b1);
        repeat (4) @(negedge clk);
        chk("drop_idle_busy", 128'(bus.oBusy), 128'(0));
        chk("drop_key_hold", 128'(bus.oKeyWord), 128'h16161616);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 128'(sb_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
